// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared state encoding and default timing constants for the PLL reset generator.
package pll_rst_pkg;
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    DEBOUNCE  = 2'd1,
    STRETCH   = 2'd2,
    RUN       = 2'd3
  } state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 1024;
  localparam int DEF_STRETCH_CYCLES  = 64;
endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: multi-flop single-bit synchroniser, every stage reset to 0.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= '0;
    else r_sync <= {r_sync[STAGES-2:0], i_d};
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/pll_lock_reset_gen.sv
// pll_lock_reset_gen: synchronises and debounces PLL lock, stretches the downstream reset and counts lock losses.
module pll_lock_reset_gen
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STRETCH_CYCLES  = DEF_STRETCH_CYCLES,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lock_i,
  input  logic             clr_i,
  output logic             rst_n_o,
  output logic             ready_o,
  output logic             lock_lost_o,
  output logic [CNT_W-1:0] lock_loss_cnt_o,
  output logic [1:0]       state_o
);
  localparam int MAXC = DEBOUNCE_CYCLES > STRETCH_CYCLES ? DEBOUNCE_CYCLES : STRETCH_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (STRETCH_CYCLES < 1) begin : g_bad_str
    $error("STRETCH_CYCLES must be >= 1");
  end
  logic             w_lock_s;
  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_run, r_lost;
  logic [CNT_W-1:0] r_loss_cnt, w_cnt_base;
  logic             w_loss;
  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (lock_i),
    .o_q  (w_lock_s)
  );
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      WAIT_LOCK: begin
        w_cnt_nxt = '0;
        if (w_lock_s) w_state_nxt = DEBOUNCE;
      end
      DEBOUNCE:
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          w_state_nxt = STRETCH;
          w_cnt_nxt   = '0;
        end else w_cnt_nxt = r_cnt + CW'(1);
      STRETCH:
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(STRETCH_CYCLES - 1)) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else w_cnt_nxt = r_cnt + CW'(1);
      RUN:
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
    endcase
  end
  // A clear coincident with a loss takes effect first, so the loss still registers.
  assign w_loss     = (r_state == RUN) && !w_lock_s;
  assign w_cnt_base = clr_i ? '0 : r_loss_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= WAIT_LOCK;
      r_cnt      <= '0;
      r_run      <= 1'b0;
      r_lost     <= 1'b0;
      r_loss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_run      <= (w_state_nxt == RUN);
      r_lost     <= w_loss || (r_lost && !clr_i);
      r_loss_cnt <= (w_loss && w_cnt_base != CNT_MAX) ? w_cnt_base + CNT_W'(1) : w_cnt_base;
    end
  assign rst_n_o         = r_run;
  assign ready_o         = r_run;
  assign lock_lost_o     = r_lost;
  assign lock_loss_cnt_o = r_loss_cnt;
  assign state_o         = r_state;
endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// tb_pll_lock_reset_gen: table-driven stimulus with a cycle-stamped expectation scoreboard.
module tb_pll_lock_reset_gen;
  typedef struct {
    logic       lock;
    logic       clr;
    int         n;
    logic [8:0] v;
  } step_t;
  typedef struct {
    int         cyc;
    string      nm;
    logic [8:0] v;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       rst_n_o, ready_o, lock_lost_o;
  logic [3:0] lock_loss_cnt_o;
  logic [1:0] state_o;
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;
  exp_t       q[$];
  step_t      tbl[14];
  pll_lock_reset_gen #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16),
    .STRETCH_CYCLES (8),
    .CNT_W          (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lock_i         (lock_i),
    .clr_i          (clr_i),
    .rst_n_o        (rst_n_o),
    .ready_o        (ready_o),
    .lock_lost_o    (lock_lost_o),
    .lock_loss_cnt_o(lock_loss_cnt_o),
    .state_o        (state_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Packed view {rst_n_o, ready_o, state, lost, cnt} used for every comparison.
  function automatic logic [8:0] pk(input bit r, input bit y, input int s, input bit l, input int c);
    return {r, y, s[1:0], l, c[3:0]};
  endfunction
  function automatic logic [8:0] outs();
    return {rst_n_o, ready_o, state_o, lock_lost_o, lock_loss_cnt_o};
  endfunction
  task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got {rst_n_o,ready_o,state,lost,cnt}=%b_%b_%0d_%b_%0d expected %b_%b_%0d_%b_%0d",
               nm, cyc, got[8], got[7], got[6:5], got[4], got[3:0], exp[8], exp[7], exp[6:5], exp[4], exp[3:0]);
    end
  endtask
  task automatic drain();
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        fails++;
        $display("FAIL %s: expectation for cycle %0d not compared (now %0d)", e.nm, e.cyc, cyc);
      end else chk(e.nm, outs(), e.v);
    end
  endtask
  task automatic wait_neg(input int n);
    repeat (n) begin
      @(negedge clk);
      drain();
    end
  endtask
  task automatic step(input step_t s, input string nm);
    lock_i = s.lock;
    clr_i  = s.clr;
    q.push_back('{cyc + s.n, nm, s.v});
    wait_neg(s.n);
  endtask
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 chk("async_rst", outs(), 9'd0);
    wait_neg(1);
    chk("held_rst", outs(), 9'd0);
    rst_n = 1'b1;
  endtask
  initial begin
    tbl[0]  = '{1'b0, 1'b0, 10, pk(0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b1, 1'b0, 2,  pk(0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b1, 1'b0, 1,  pk(0, 0, 1, 0, 0)};
    tbl[3]  = '{1'b1, 1'b0, 16, pk(0, 0, 2, 0, 0)};
    tbl[4]  = '{1'b1, 1'b0, 7,  pk(0, 0, 2, 0, 0)};
    tbl[5]  = '{1'b1, 1'b0, 1,  pk(1, 1, 3, 0, 0)};
    tbl[6]  = '{1'b1, 1'b0, 20, pk(1, 1, 3, 0, 0)};
    tbl[7]  = '{1'b0, 1'b0, 2,  pk(1, 1, 3, 0, 0)};
    tbl[8]  = '{1'b0, 1'b0, 1,  pk(0, 0, 0, 1, 1)};
    tbl[9]  = '{1'b0, 1'b0, 2,  pk(0, 0, 0, 1, 1)};
    tbl[10] = '{1'b1, 1'b0, 26, pk(0, 0, 2, 1, 1)};
    tbl[11] = '{1'b1, 1'b0, 1,  pk(1, 1, 3, 1, 1)};
    tbl[12] = '{1'b1, 1'b1, 1,  pk(1, 1, 3, 0, 0)};
    tbl[13] = '{1'b1, 1'b0, 3,  pk(1, 1, 3, 0, 0)};
    #1 chk("reset_state", outs(), 9'd0);
    wait_neg(2);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("tbl%0d", i));
    step(step_t'{1'b0, 1'b0, 3, pk(0, 0, 0, 1, 1)}, "mid_drop");
    step(step_t'{1'b1, 1'b0, 22, pk(0, 0, 2, 1, 1)}, "mid_stretch");
    pulse_reset();
    step(step_t'{1'b1, 1'b0, 26, pk(0, 0, 2, 0, 0)}, "rst_restretch");
    step(step_t'{1'b1, 1'b0, 1, pk(1, 1, 3, 0, 0)}, "rst_release");
    lock_i = 1'b0;
    pulse_reset();
    step(step_t'{1'b1, 1'b0, 3, pk(0, 0, 1, 0, 0)}, "gl_deb");
    step(step_t'{1'b1, 1'b0, 7, pk(0, 0, 1, 0, 0)}, "gl_deb_hold");
    step(step_t'{1'b0, 1'b0, 2, pk(0, 0, 1, 0, 0)}, "gl_low_sync");
    step(step_t'{1'b0, 1'b0, 1, pk(0, 0, 0, 0, 0)}, "gl_wait");
    step(step_t'{1'b1, 1'b0, 2, pk(0, 0, 0, 0, 0)}, "gl_relock");
    step(step_t'{1'b1, 1'b0, 24, pk(0, 0, 2, 0, 0)}, "gl_stretch");
    step(step_t'{1'b1, 1'b0, 1, pk(1, 1, 3, 0, 0)}, "gl_release");
    for (int i = 1; i <= 17; i++) begin
      step(step_t'{1'b0, 1'b0, 3, pk(0, 0, 0, 1, i > 15 ? 15 : i)}, $sformatf("sat_loss%0d", i));
      step(step_t'{1'b1, 1'b0, 27, pk(1, 1, 3, 1, i > 15 ? 15 : i)}, $sformatf("sat_run%0d", i));
    end
    step(step_t'{1'b0, 1'b0, 2, pk(1, 1, 3, 1, 15)}, "co_pre");
    step(step_t'{1'b0, 1'b1, 1, pk(0, 0, 0, 1, 1)}, "co_clr_loss");
    step(step_t'{1'b1, 1'b0, 27, pk(1, 1, 3, 1, 1)}, "co_rerun");
    step(step_t'{1'b1, 1'b1, 1, pk(1, 1, 3, 0, 0)}, "clr_pulse");
    step(step_t'{1'b1, 1'b0, 2, pk(1, 1, 3, 0, 0)}, "clr_after");
    while (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL %s: expectation never compared", q[0].nm);
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
